input_stream_fifo: RTL
======================

Name: input_stream_fifo

Overview:
- Buffers the Avalon-ST receive stream from the MAC ahead of the packet controller and comparators.
- Presents a first-word-fall-through stream downstream.
- Applies backpressure upstream, and guarantees downstream always sees well-formed packets (sop … eop), even when the MAC overruns the buffer.
- Packets cut short by overflow are closed with a terminator word flagged in error bit 5.

Parameters:
DATA_W, 32, stream data width
DEPTH, 16, FIFO entries; power of two, minimum 4
AFULL_MARGIN, 2, free entries kept in reserve when deasserting in_ready

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of contents and state
in_data  in  DATA_W  MAC data
in_valid  in  1  MAC word valid
in_sop  in  1  start of packet
in_eop  in  1  end of packet
in_empty  in  2  unused byte lanes on eop word
in_error  in  6  MAC error flags
in_ready  out  1  backpressure to MAC
out_data  out  DATA_W  head word data
out_valid  out  1  head word present
out_sop  out  1  head sop
out_eop  out  1  head eop
out_empty  out  2  head empty
out_error  out  6  head error
out_ready  in  1  consumer ready (controller ready)
level  out  $clog2(DEPTH)+1  entries stored
overflow_cnt  out  16  words dropped (feature-dependent)
max_level  out  $clog2(DEPTH)+1  high-water mark (feature-dependent)

Behaviour:
- Reset: pointers 0, level 0, state PASS, out_valid 0, in_ready 1, overflow_cnt 0, max_level 0.
- Storage and output:
  - Each entry holds {data, sop, eop, empty, error}.
  - Outputs are driven from the head entry; out_* other than out_valid are don't-care when out_valid=0.
  - A word written at edge N appears with out_valid=1 in cycle N+1.
- Transfers:
  - Read: fires when out_valid & out_ready.
  - Write: fires when accepted (rules below) and level<DEPTH.
  - Full (level==DEPTH): a write is refused even if a read fires in the same cycle.
  - A simultaneous read and write leaves level unchanged.
- in_ready = (level < DEPTH-AFULL_MARGIN), combinational from registered level. The MAC may ignore in_ready; words arriving while level<DEPTH are still stored.
- State machine:
  - PASS:
    - in_valid & not full: write the word.
    - in_valid & full & in_sop: drop the word, go to DROP with need_term=0.
    - in_valid & full & not in_sop: drop the word, go to DROP with need_term=1.
  - DROP: discard every in_valid word.
    - On in_valid & in_eop with need_term=0: go to PASS.
    - On in_valid & in_eop with need_term=1: go to TERM.
  - TERM:
    - When not full, write terminator {data 0, sop 0, eop 1, empty 3, error 6'b100000}, then go to PASS.
    - Input words arriving in TERM are discarded.
    - An in_sop word arriving in TERM forces need_term=0 for its own drop and goes to DROP. The terminator still has priority if space exists in that cycle: write the terminator and drop the word.
- Single-word packet (sop & eop) dropped while full in PASS: stays in PASS, no terminator.
- overflow_cnt: +1 per discarded in_valid word, saturates at 16'hFFFF.
- flush: clears pointers and level and returns to PASS; counters are kept. flush and reset mid-packet leave no partial packet buffered.
- Pointers: $clog2(DEPTH) bits, wrap naturally.

Optional Feature:
STREAM_FIFO_STATS_EN
- Defined:
  - overflow_cnt is live as specified.
  - max_level tracks the maximum level since reset/flush, registered.
- Undefined:
  - Both ports are tied to 0.
  - Counter logic is absent; drop behaviour is unchanged.

Decomposition:
- sniffer_pkg:
  - typedef stream_word_t struct (data, sop, eop, empty, error).
  - fifo_state_t enum {PASS, DROP, TERM}.
  - Constant ERR_OVERFLOW_BIT=5.
  - Constant TERM_WORD.
- Sub-module fifo_ram: DEPTH×stream_word_t array with one write port and one asynchronous read port. Pointers and FSM stay in the top level.

Test Plan:
- Pass-through: 5-word packet (sop on word 0, eop+empty=2 on word 4), out_ready=1 → identical 5 words out; first word 1 cycle after write; level returns to 0.
- Backpressure: DEPTH=16, out_ready=0, stream 20 words honouring in_ready → in_ready drops when level=14; nothing lost; drains in order once out_ready=1.
- Mid-packet overflow: out_ready=0, MAC ignores in_ready, 20-word packet → 16 stored, 4 dropped, overflow_cnt=4. Raising out_ready → the 16 words, then terminator with eop=1, empty=3, error=6'b100000.
- Overflow at sop: FIFO full, new 3-word packet → all 3 dropped, no terminator, state PASS after eop, overflow_cnt+=3.
- TERM with new sop: full in TERM, next packet's sop arrives → that packet fully dropped; terminator written when space frees; following packet passes intact.
- Flush mid-packet: 6 words stored, flush pulse → level=0, out_valid=0 next cycle, overflow_cnt unchanged.

Source files
------------

// File: rtl/sniffer_pkg.sv
// Shared types and constants for the receive-stream FIFO: stored word layout,
// drop-state encoding and the overflow terminator word.
package sniffer_pkg;

  localparam int STREAM_DATA_W    = 32;
  localparam int ERR_OVERFLOW_BIT = 5;

  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
    logic                     sop;
    logic                     eop;
    logic [1:0]               empty;
    logic [5:0]               error;
  } stream_word_t;

  typedef enum logic [1:0] {
    PASS,
    DROP,
    TERM
  } fifo_state_t;

  // Closes a packet that lost its tail to overflow.
  localparam stream_word_t TERM_WORD = '{
    data:  '0,
    sop:   1'b0,
    eop:   1'b1,
    empty: 2'd3,
    error: 6'(1 << ERR_OVERFLOW_BIT)
  };

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the receive-stream FIFO: one synchronous write port and
// one asynchronous read port so the head word falls through combinationally.
module fifo_ram
  import sniffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  stream_word_t wr_word,
  input  logic [AW-1:0] rd_addr,
  output stream_word_t rd_word
);

  stream_word_t mem [DEPTH];

  // NOTE: the array has no reset; valid contents are defined by the pointers,
  // and a reset on every entry would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/input_stream_fifo.sv
// First-word-fall-through buffer for the MAC receive stream that keeps packets
// well-formed on overflow. Define STREAM_FIFO_STATS_EN for overflow/high-water stats.
// DATA_W must equal STREAM_DATA_W in sniffer_pkg.
module input_stream_fifo
  import sniffer_pkg::*;
#(
  parameter  int DATA_W       = STREAM_DATA_W,
  parameter  int DEPTH        = 16,
  parameter  int AFULL_MARGIN = 2,
  localparam int AW           = $clog2(DEPTH),
  localparam int LW           = AW + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_empty,
  input  logic [5:0]        in_error,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_empty,
  output logic [5:0]        out_error,
  input  logic              out_ready,
  output logic [LW-1:0]     level,
  output logic [15:0]       overflow_cnt,
  output logic [LW-1:0]     max_level
);

  fifo_state_t   state, state_n;
  logic          need_term, need_term_n;
  logic          term_owed, term_owed_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_n;
  logic          full, rd_fire, wr_en, drop;
  stream_word_t  in_word, wr_word, head;

  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign rd_fire   = out_valid & out_ready;
  assign in_ready  = (level < LW'(DEPTH - AFULL_MARGIN));
  assign level_n   = level + LW'(wr_en) - LW'(rd_fire);

  assign in_word = '{
    data:  in_data,
    sop:   in_sop,
    eop:   in_eop,
    empty: in_empty,
    error: in_error
  };

  // need_term: the packet being dropped was partly stored and needs closing.
  // term_owed: an earlier packet still needs its terminator while a new
  // packet (which arrived during TERM) is being dropped.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_n     = state;
    need_term_n = need_term;
    term_owed_n = term_owed;
    wr_en       = 1'b0;
    wr_word     = in_word;
    drop        = 1'b0;

    unique case (state)
      PASS: begin
        if (in_valid) begin
          if (!full) begin
            wr_en = 1'b1;
          end else begin
            drop = 1'b1;
            if (in_sop && in_eop) begin
              state_n = PASS;
            end else if (in_sop) begin
              state_n     = DROP;
              need_term_n = 1'b0;
            end else if (in_eop) begin
              // The dropped word was already the tail: only the terminator remains.
              state_n = TERM;
            end else begin
              state_n     = DROP;
              need_term_n = 1'b1;
            end
          end
        end
      end

      DROP: begin
        if (term_owed && !full) begin
          wr_en       = 1'b1;
          wr_word     = TERM_WORD;
          term_owed_n = 1'b0;
        end
        if (in_valid) begin
          drop = 1'b1;
          if (in_eop) begin
            state_n     = (need_term || term_owed_n) ? TERM : PASS;
            need_term_n = 1'b0;
            term_owed_n = 1'b0;
          end
        end
      end

      TERM: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_word = TERM_WORD;
          state_n = PASS;
        end
        if (in_valid) begin
          drop = 1'b1;
          // A new packet's sop is dropped whole; its own drop needs no terminator.
          if (in_sop && !in_eop) begin
            state_n     = DROP;
            need_term_n = 1'b0;
            term_owed_n = full;
          end
        end
      end

      default: state_n = PASS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= PASS;
      need_term <= 1'b0;
      term_owed <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else if (flush) begin
      state     <= PASS;
      need_term <= 1'b0;
      term_owed <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state     <= state_n;
      need_term <= need_term_n;
      term_owed <= term_owed_n;
      level     <= level_n;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_word (wr_word),
    .rd_addr (rd_ptr),
    .rd_word (head)
  );

  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;
  assign out_empty = head.empty;
  assign out_error = head.error;

`ifdef STREAM_FIFO_STATS_EN
  logic [15:0]   ovf_q;
  logic [LW-1:0] max_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= '0;
      max_q <= '0;
    end else begin
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
      if (flush) begin
        max_q <= '0;
      end else if (level_n > max_q) begin
        max_q <= level_n;
      end
    end
  end

  assign overflow_cnt = ovf_q;
  assign max_level    = max_q;
`else
  logic unused_drop;
  assign unused_drop  = drop;
  assign overflow_cnt = '0;
  assign max_level    = '0;
`endif

endmodule
